// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump/branch flushes and data-memory
// freeze with a timeout watchdog, plus saturating stall/flush performance counters.
//
// state | meaning
// RUN   | normal operation, no outstanding memory wait
// WAIT  | data memory access pending, wait_cnt counting wait cycles
// ERR   | memory timed out; pipeline frozen until rst
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        jb,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        clr_cnt,
  output logic        stall_pc,
  output logic        stall_d,
  output logic        flush_d,
  output logic        bubble_e,
  output logic        hold_e,
  output logic        hold_m,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic freeze;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign freeze   = (mem_req && !mem_ready) || (state_q == ST_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // The RUN->WAIT cycle is wait cycle 0, so ERR is entered after wait_cnt 255.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = 8'd0;
        if (mem_req && !mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready || !mem_req)     state_d = ST_RUN;
        else if (wait_cnt_q == 8'd255) state_d = ST_ERR;
        else                           wait_cnt_d = wait_cnt_q + 8'd1;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    mem_timeout_d = mem_timeout_q || (state_d == ST_ERR);
  end

  // A jb seen while frozen is ignored: EX is held, so the branch is re-presented later.
  always_comb begin
    stall_pc = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    hold_e   = 1'b0;
    hold_m   = 1'b0;
    if (freeze) begin
      stall_pc = 1'b1;
      stall_d  = 1'b1;
      hold_e   = 1'b1;
      hold_m   = 1'b1;
    end else if (jb) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (load_use) begin
      stall_pc = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (stall_pc && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_d && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; hazard outputs are compared as a packed
// vector {stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m}.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, jb, mem_req, mem_ready, clr_cnt;
  logic        stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] H_NONE   = 6'b000000;
  localparam logic [5:0] H_LOAD   = 6'b110100;
  localparam logic [5:0] H_JB     = 6'b001100;
  localparam logic [5:0] H_FREEZE = 6'b110011;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .jb         (jb),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .clr_cnt    (clr_cnt),
    .stall_pc   (stall_pc),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .bubble_e   (bubble_e),
    .hold_e     (hold_e),
    .hold_m     (hold_m),
    .mem_timeout(mem_timeout),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  wire [5:0] haz = {stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
    jb = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_haz", {10'd0, haz}, {10'd0, H_NONE});
    check("reset_stall_cnt", stall_cnt, 16'd0);
    check("reset_flush_cnt", flush_cnt, 16'd0);
    check("reset_timeout", {15'd0, mem_timeout}, 16'd0);
    step();
    rst = 1'b0;

    // load-use through rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("lu_rs1_haz", {10'd0, haz}, {10'd0, H_LOAD});
    step();
    idle_inputs();
    check("lu_rs1_cnt", stall_cnt, 16'd1);

    // load-use through rs2
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("lu_rs2_haz", {10'd0, haz}, {10'd0, H_LOAD});
    step();
    idle_inputs();
    check("lu_rs2_cnt", stall_cnt, 16'd2);

    // x0 destination never stalls
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("lu_x0_haz", {10'd0, haz}, {10'd0, H_NONE});
    step();
    idle_inputs();
    // rs1 matches but is not read
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    @(negedge clk);
    check("lu_unused_haz", {10'd0, haz}, {10'd0, H_NONE});
    step();
    // register mismatch
    id_rs1 = 5'd6; id_use_rs1 = 1'b1;
    @(negedge clk);
    check("lu_mismatch_haz", {10'd0, haz}, {10'd0, H_NONE});
    step();
    // not a load
    id_rs1 = 5'd5; ex_is_load = 1'b0;
    @(negedge clk);
    check("lu_noload_haz", {10'd0, haz}, {10'd0, H_NONE});
    step();
    idle_inputs();
    check("no_stall_cnt", stall_cnt, 16'd2);
    check("no_flush_cnt", flush_cnt, 16'd0);

    // jb beats load-use
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; jb = 1'b1;
    @(negedge clk);
    check("jb_lu_haz", {10'd0, haz}, {10'd0, H_JB});
    step();
    idle_inputs();
    check("jb_lu_flush_cnt", flush_cnt, 16'd1);
    check("jb_lu_stall_cnt", stall_cnt, 16'd2);

    // freeze beats jb for three cycles, flush lands on the ready cycle
    jb = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("freeze_jb_haz", {10'd0, haz}, {10'd0, H_FREEZE});
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("ready_jb_haz", {10'd0, haz}, {10'd0, H_JB});
    step();
    idle_inputs();
    @(negedge clk);
    check("after_wait_haz", {10'd0, haz}, {10'd0, H_NONE});
    check("after_wait_stall_cnt", stall_cnt, 16'd5);
    check("after_wait_flush_cnt", flush_cnt, 16'd2);
    check("after_wait_timeout", {15'd0, mem_timeout}, 16'd0);

    // WAIT left via dropped mem_req
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    @(negedge clk);
    check("wait_drop_haz", {10'd0, haz}, {10'd0, H_NONE});
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_stall_cnt", stall_cnt, 16'd0);
    check("clr_flush_cnt", flush_cnt, 16'd0);

    // timeout: cycle 0 is the RUN->WAIT cycle, WAIT cycles carry wait_cnt 0..255
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (256) step();
    @(negedge clk);
    check("timeout_edge_before", {15'd0, mem_timeout}, 16'd0);
    step();
    @(negedge clk);
    check("timeout_set", {15'd0, mem_timeout}, 16'd1);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    check("err_ready_haz", {10'd0, haz}, {10'd0, H_FREEZE});
    step();
    mem_req = 1'b0; jb = 1'b1;
    @(negedge clk);
    check("err_idle_haz", {10'd0, haz}, {10'd0, H_FREEZE});
    step();
    jb = 1'b0;
    check("err_stall_cnt", stall_cnt, 16'd260);
    check("err_flush_cnt", flush_cnt, 16'd0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("err_clr_cnt", stall_cnt, 16'd0);
    check("err_clr_timeout", {15'd0, mem_timeout}, 16'd1);
    @(negedge clk);
    check("err_clr_haz", {10'd0, haz}, {10'd0, H_FREEZE});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_err_timeout", {15'd0, mem_timeout}, 16'd0);
    check("rst_err_haz", {10'd0, haz}, {10'd0, H_NONE});
    check("rst_err_stall_cnt", stall_cnt, 16'd0);

    // rst aborts an in-progress wait
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1; mem_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_haz", {10'd0, haz}, {10'd0, H_NONE});
    check("rst_wait_stall_cnt", stall_cnt, 16'd0);

    // stall counter saturation and clear precedence
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    repeat (65535) step();
    check("sat_reach", stall_cnt, 16'hFFFF);
    step();
    check("sat_hold", stall_cnt, 16'hFFFF);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("sat_clr", stall_cnt, 16'd0);
    step();
    check("post_clr_inc", stall_cnt, 16'd1);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
